// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage with data-memory handshake, load alignment,
// branch/jump redirect and the MEM/WB pipeline register.
module mem_wb_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3004,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  EX_MEM_LS_bit,
  input  logic [1:0]  EX_MEM_Branch,
  input  logic        EX_MEM_MemtoReg,
  input  logic        EX_MEM_MemWrite,
  input  logic        EX_MEM_RegWrite,
  input  logic        EX_MEM_Jump,
  input  logic        EX_MEM_Ext_op,
  input  logic        EX_MEM_PctoReg,
  input  logic [31:0] EX_MEM_branch_add_out,
  input  logic        EX_MEM_zero,
  input  logic [31:0] EX_MEM_pc_add_out,
  input  logic [25:0] EX_MEM_instr26,
  input  logic [31:0] EX_MEM_alu_out,
  input  logic [31:0] EX_MEM_regfile_out2,
  input  logic [4:0]  EX_MEM_mux1_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        misalign_err,
  output logic        timeout_err,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_MemtoReg,
  output logic        MEM_WB_PctoReg,
  output logic [31:0] MEM_WB_mem_data,
  output logic [31:0] MEM_WB_alu_out,
  output logic [31:0] MEM_WB_pc_add_out,
  output logic [4:0]  MEM_WB_mux1_out
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [1:0] a;
  logic is_half, is_byte, mem_op, misaligned, access, to_hit, to_fail, taken;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;
  assign a          = EX_MEM_alu_out[1:0];
  assign is_half    = EX_MEM_LS_bit == 2'b01;
  assign is_byte    = EX_MEM_LS_bit == 2'b10;
  assign mem_op     = EX_MEM_MemtoReg | EX_MEM_MemWrite;
  assign misaligned = mem_op & (is_half ? a[0] : (!is_byte && a != 2'b00));
  assign access     = mem_op & ~misaligned;
  assign to_hit     = state == S_WAIT && cnt == 8'(MEM_TIMEOUT);
  assign to_fail    = to_hit & ~dmem_ready;
  assign taken      = (EX_MEM_Branch == 2'b01 & EX_MEM_zero) | (EX_MEM_Branch == 2'b10 & ~EX_MEM_zero);
  assign ld_b       = 8'(dmem_rdata >> {a, 3'b000});
  assign ld_h       = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign ld_data    = is_byte ? {{24{EX_MEM_Ext_op & ld_b[7]}}, ld_b}
                    : is_half ? {{16{EX_MEM_Ext_op & ld_h[15]}}, ld_h} : dmem_rdata;
  // Every combinational output is forced low while reset is held.
  assign dmem_req    = reset & access & ~to_fail;
  assign dmem_we     = dmem_req & EX_MEM_MemWrite;
  assign dmem_addr   = reset ? {EX_MEM_alu_out[31:2], 2'b00} : 32'h0;
  assign dmem_be     = !reset ? 4'h0 : !EX_MEM_MemWrite ? 4'hF
                     : is_byte ? 4'b0001 << a : is_half ? (a[1] ? 4'b1100 : 4'b0011) : 4'hF;
  assign dmem_wdata  = !reset ? 32'h0 : is_byte ? {4{EX_MEM_regfile_out2[7:0]}}
                     : is_half ? {2{EX_MEM_regfile_out2[15:0]}} : EX_MEM_regfile_out2;
  assign mem_stall   = reset & access & ~dmem_ready & ~to_hit;
  assign redirect    = reset & (EX_MEM_Jump | taken) & ~mem_stall;
  assign redirect_pc = !reset ? 32'h0 : EX_MEM_Jump
                     ? {EX_MEM_pc_add_out[31:28], EX_MEM_instr26, 2'b00} : EX_MEM_branch_add_out;
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (state == S_IDLE) begin
      state_d = access & ~dmem_ready ? S_WAIT : S_IDLE;
      cnt_d   = access & ~dmem_ready ? 8'd1 : 8'd0;
    end else if (dmem_ready | ~access | to_hit) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
    end else begin
      cnt_d = cnt + 8'd1;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      cnt               <= 8'd0;
      misalign_err      <= 1'b0;
      timeout_err       <= 1'b0;
      MEM_WB_RegWrite   <= 1'b0;
      MEM_WB_MemtoReg   <= 1'b0;
      MEM_WB_PctoReg    <= 1'b0;
      MEM_WB_mem_data   <= 32'h0;
      MEM_WB_alu_out    <= 32'h0;
      MEM_WB_pc_add_out <= RESET_PC;
      MEM_WB_mux1_out   <= 5'd0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      misalign_err <= misaligned;
      timeout_err  <= timeout_err | to_fail;
      if (mem_stall) begin
        MEM_WB_RegWrite <= 1'b0;
        MEM_WB_MemtoReg <= 1'b0;
        MEM_WB_PctoReg  <= 1'b0;
      end else begin
        MEM_WB_RegWrite   <= EX_MEM_RegWrite & ~misaligned & ~to_fail;
        MEM_WB_MemtoReg   <= EX_MEM_MemtoReg;
        MEM_WB_PctoReg    <= EX_MEM_PctoReg;
        MEM_WB_mem_data   <= ld_data;
        MEM_WB_alu_out    <= EX_MEM_alu_out;
        MEM_WB_pc_add_out <= EX_MEM_pc_add_out;
        MEM_WB_mux1_out   <= EX_MEM_mux1_out;
      end
    end
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register; sits directly downstream of the EX/MEM register and consumes its outputs.
- Drives the data-memory request/ready handshake and generates store byte-enables.
- Aligns and extends load data; resolves branch/jump redirect; registers writeback fields for the WB stage.
- Stalls the pipeline while memory is not ready and flags misaligned or timed-out accesses.

Parameters:
RESET_PC, 32'h0000_3004, reset value of MEM_WB_pc_add_out
MEM_TIMEOUT, 255, WAIT cycles before an access is abandoned (8-bit counter, range 1..255)

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset
EX_MEM_LS_bit  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word
EX_MEM_Branch  in  2  00 none, 01 beq, 10 bne, 11 none
EX_MEM_MemtoReg / EX_MEM_MemWrite / EX_MEM_RegWrite / EX_MEM_Jump / EX_MEM_Ext_op / EX_MEM_PctoReg  in  1 each  control from EX/MEM
EX_MEM_branch_add_out  in  32  branch target
EX_MEM_zero  in  1  ALU zero flag
EX_MEM_pc_add_out  in  32  PC+4
EX_MEM_instr26  in  26  jump index
EX_MEM_alu_out  in  32  effective address / ALU result
EX_MEM_regfile_out2  in  32  store data
EX_MEM_mux1_out  in  5  destination register
dmem_req  out  1  access request
dmem_we  out  1  write strobe
dmem_addr  out  32  {alu_out[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  read data, valid when dmem_ready
dmem_ready  in  1  access complete this cycle
mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
redirect  out  1  take redirect_pc next cycle; flush younger stages
redirect_pc  out  32  branch or jump target
misalign_err  out  1  one-cycle pulse, registered
timeout_err  out  1  sticky until reset
MEM_WB_RegWrite / MEM_WB_MemtoReg / MEM_WB_PctoReg  out  1 each
MEM_WB_mem_data / MEM_WB_alu_out / MEM_WB_pc_add_out  out  32 each
MEM_WB_mux1_out  out  5

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE, wait counter 0.
  - All MEM_WB_* outputs 0 except MEM_WB_pc_add_out = RESET_PC.
  - misalign_err and timeout_err 0.
  - Combinational outputs are 0 while in reset.
- access = (MemtoReg | MemWrite) & ~misaligned.
- misaligned = (half & addr[0]) | (word & addr[1:0]!=0).
- Store byte-enables and data:
  - byte: be = 1 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}.
  - word: be = 1111, wdata = rs2.
  - Loads: be = 1111, dmem_we = 0.
- Load data:
  - Byte selected by addr[1:0]; half selected by addr[1].
  - Ext_op=1 sign-extends; Ext_op=0 zero-extends.
  - Word loads pass through unchanged.
- FSM IDLE/WAIT:
  - dmem_req = access in both states.
  - IDLE: if access & ~ready, go to WAIT and set counter to 1.
  - WAIT: on ready, return to IDLE. Otherwise increment the counter. When counter == MEM_TIMEOUT and ~ready, set timeout_err, drop the request, and return to IDLE treating the access as complete with RegWrite forced to 0.
  - Zero-wait access: access & ready in IDLE completes the same cycle with no stall.
- mem_stall = access & ~dmem_ready & ~(WAIT & counter==MEM_TIMEOUT).
- MEM/WB update, every rising edge:
  - Stalled edge: register a bubble (all control 0, data don't-care held).
  - Otherwise: capture the EX/MEM fields and the extended load data.
  - Misaligned access: suppress the memory request, force MEM_WB_RegWrite=0, pulse misalign_err for 1 cycle.
- Redirect:
  - taken = (Branch==01 & zero) | (Branch==10 & ~zero).
  - redirect = (Jump | taken) & ~mem_stall.
  - Jump has priority: redirect_pc = {pc_add_out[31:28], instr26, 2'b00}; otherwise branch_add_out.
- Latency: 1 cycle from EX/MEM to MEM_WB when no wait states; N wait states add N stall cycles.
- Reset asserted mid-WAIT: the request drops immediately and state returns to IDLE.

Test Plan:
- Load word, addr 0x100, Ext_op=1, ready same cycle, rdata 0xDEADBEEF → no stall; next edge MEM_WB_mem_data=0xDEADBEEF, MEM_WB_RegWrite=1.
- Load byte, addr 0x103, rdata 0x80112233, Ext_op=1 → 0xFFFFFF80; repeat with Ext_op=0 → 0x00000080.
- Store half, addr 0x202, rs2 0x0000ABCD → be=1100, wdata=0xABCDABCD, we=1.
- Load with ready delayed 3 cycles → mem_stall high 3 cycles, 3 bubbles with RegWrite=0, then one valid write.
- Load word at addr 0x101 → dmem_req=0, misalign_err pulses 1 cycle, MEM_WB_RegWrite=0; with ready held low for 255 cycles → timeout_err=1, stall releases.
- beq with zero=1, target 0x3040, Jump=0 → redirect=1, redirect_pc=0x3040; Jump=1 with instr26=0x0000C10, pc_add_out=0x00003008 → redirect_pc=0x00003040; async reset mid-WAIT → outputs cleared, MEM_WB_pc_add_out=0x00003004.
